// File: rtl/bist_state_machine_pkg.sv
// Shared types and default cycle counts for the BIST sequencer.
package bist_state_machine_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INIT   = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } bist_state_t;

  localparam int DEF_INIT_CYCLES = 2;
  localparam int DEF_RUN_CYCLES  = 10;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/bist_cycle_counter.sv
// Loadable down-counter that saturates at zero; zero flag reflects the current count.
module bist_cycle_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset)           cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (dec && !zero) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/bist_state_machine.sv
// BIST sequencer: IDLE -> INIT -> RUN -> FINISH with registered one-hot phase outputs.
// Optional STATE_MACHINE_ABORT_EN: dropping bist_start in INIT/RUN returns to IDLE.
module bist_state_machine
  import bist_state_machine_pkg::*;
#(
  parameter int INIT_CYCLES = DEF_INIT_CYCLES,
  parameter int RUN_CYCLES  = DEF_RUN_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic bist_start,
  output logic mode,
  output logic bist_end,
  output logic init,
  output logic running,
  output logic finish
);

`ifdef STATE_MACHINE_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] INIT_LD = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LD  = CNT_W'(RUN_CYCLES - 1);

  bist_state_t      state, state_nxt;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;

  bist_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_dec   = 1'b0;
    case (state)
      IDLE: if (bist_start) begin
        state_nxt = INIT;
        cnt_load  = 1'b1;
        cnt_val   = INIT_LD;
      end
      INIT: begin
        if (ABORT_EN && !bist_start) state_nxt = IDLE;
        else if (cnt_zero) begin
          state_nxt = RUN;
          cnt_load  = 1'b1;
          cnt_val   = RUN_LD;
        end else cnt_dec = 1'b1;
      end
      RUN: begin
        if (ABORT_EN && !bist_start) state_nxt = IDLE;
        else if (cnt_zero)           state_nxt = FINISH;
        else                         cnt_dec   = 1'b1;
      end
      FINISH: if (!bist_start) state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they switch on the same edge as state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      mode     <= 1'b0;
      bist_end <= 1'b0;
      init     <= 1'b0;
      running  <= 1'b0;
      finish   <= 1'b0;
    end else begin
      state    <= state_nxt;
      mode     <= (state_nxt == INIT) || (state_nxt == RUN);
      bist_end <= (state_nxt == FINISH) && (state != FINISH);
      init     <= (state_nxt == INIT);
      running  <= (state_nxt == RUN);
      finish   <= (state_nxt == FINISH);
    end
  end

endmodule

// File: tb/tb_bist_state_machine.sv
// Scoreboard bench for bist_state_machine: expected outputs queued per driven edge, compared after it.
module tb_bist_state_machine;

  localparam int INIT_C = 2;
  localparam int RUN_C  = 10;

`ifdef STATE_MACHINE_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic bist_start = 1'b0;
  logic mode, bist_end, init, running, finish;

  int n_vec = 0;
  int n_err = 0;

  logic [4:0] exp_q[$];

  // Reference model: phase 0 idle, 1 active (t = edges since start), 2 finish.
  int ph = 0;
  int t  = 0;
  bit first = 1'b0;

  bist_state_machine #(.INIT_CYCLES(INIT_C), .RUN_CYCLES(RUN_C), .CNT_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .bist_start (bist_start),
    .mode       (mode),
    .bist_end   (bist_end),
    .init       (init),
    .running    (running),
    .finish     (finish)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (mode,end,init,run,fin) at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit s);
    if (r) begin
      ph = 0; first = 1'b0;
    end else begin
      case (ph)
        0: if (s) begin ph = 1; t = 0; end
        1: begin
          t++;
          if (ABORT && !s) ph = 0;
          else if (t == INIT_C + RUN_C) begin ph = 2; first = 1'b1; end
        end
        default: begin
          first = 1'b0;
          if (!s) ph = 0;
        end
      endcase
    end
  endtask

  function automatic logic [4:0] expv();
    logic [4:0] v;
    v = 5'b0;
    if (ph == 1) v = {1'b1, 1'b0, (t < INIT_C), (t >= INIT_C), 1'b0};
    else if (ph == 2) v = {1'b0, first, 1'b0, 1'b0, 1'b1};
    return v;
  endfunction

  task automatic step(input string tag, input bit r, input bit s, input int n);
    logic [4:0] e;
    for (int i = 0; i < n; i++) begin
      reset = r;
      bist_start = s;
      model(r, s);
      exp_q.push_back(expv());
      @(posedge clock);
      #1;
      e = exp_q.pop_front();
      chk(tag, {mode, bist_end, init, running, finish}, e);
      chk({tag, "_onehot"}, {4'b0, ($countones({init, running, finish}) <= 1)}, 5'd1);
    end
  endtask

  initial begin
    step("reset",     1, 0, 1);
    step("idle_hold", 0, 0, 5);
    step("full_run",  0, 1, 25);
    step("rearm_drop",0, 0, 1);
    step("rearm_run", 0, 1, 8);
    step("mid_reset", 1, 1, 1);
    step("post_rst",  0, 1, 14);
    step("held",      0, 1, 50);
    step("release",   0, 0, 3);
    step("abort_pre", 0, 1, 5);
    step("abort",     0, 0, 15);
    step("tail",      0, 0, 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
